handshake_coef_sequencer: RTL and testbench
===========================================

Name: handshake_coef_sequencer

Overview:
- Control-token-driven coefficient sequencer for the tanh soft-clip datapath.
- Each accepted ctrl token emits NUM_COEFS constants from a parameterised table, in index order, on a valid/ready output channel.
- Replaces a bank of independent handshake constant units feeding a polynomial evaluator, so one unit sequences all coefficients onto a single shared operand channel.
- Output is registered and holds stable under backpressure.

Parameters:
- DATA_WIDTH, 32, width of outs; table entries occupy the low bits, upper bits zero.
- NUM_COEFS, 4, entries emitted per token; legal range 1..16.
- COEF_TABLE, {32'h001FFFFF, 32'h000FFFFF, 32'h00000001, 32'h001A48D7}, packed table; entry i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- IDX_W, max(1, clog2(NUM_COEFS)), width of outs_index (derived, not overridden).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- ctrl_valid  input  1  trigger token valid.
- ctrl_ready  output  1  trigger token accepted when ctrl_valid && ctrl_ready.
- outs  output  DATA_WIDTH  current coefficient (registered).
- outs_index  output  IDX_W  index of the coefficient on outs.
- outs_last  output  1  high when outs_index == NUM_COEFS-1 and outs_valid.
- outs_valid  output  1  coefficient valid.
- outs_ready  input  1  downstream accepts when outs_valid && outs_ready.

Behaviour:
- Reset (rst high at a clock edge): state=IDLE, outs=0, outs_index=0, outs_valid=0, outs_last=0; ctrl_ready=1 in the cycle after reset. Reset mid-burst abandons the burst; no further beats are emitted for it.
- States: IDLE, RUN.
- IDLE: ctrl_ready=1, outs_valid=0. On ctrl_valid at edge t -> RUN; outs=COEF_TABLE[0], outs_index=0, outs_valid=1 from t+1 (1-cycle latency).
- RUN: ctrl_ready=0; ctrl_valid is ignored and not consumed.
  - Beat fires on outs_valid && outs_ready.
  - Firing beat with index i < NUM_COEFS-1: load entry i+1, index i+1 next cycle; outs_valid stays 1 (one beat per cycle at full throughput).
  - Firing beat with index NUM_COEFS-1: -> IDLE, outs_valid=0, outs_index=0 next cycle.
- Backpressure: while outs_valid && !outs_ready, outs, outs_index and outs_last hold unchanged. outs_valid never drops without a handshake.
- outs_valid and outs_ready are independent: outs_valid does not depend on outs_ready; no combinational path from ctrl_valid to outs_valid.
- Throughput: NUM_COEFS+1 cycles per token minimum. The IDLE bubble cycle between bursts is required, not optional.
- NUM_COEFS=1: every burst is a single beat with outs_last=1; IDX_W=1, outs_index always 0.
- Index counter never wraps inside RUN; it returns to 0 only via IDLE or reset.
- Entries are taken verbatim from COEF_TABLE; no arithmetic, no sign extension.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then ctrl_valid=0 -> outs_valid=0, outs=0, ctrl_ready=1 every cycle.
- Single burst, outs_ready=1: ctrl_valid pulse at cycle 0 -> cycles 1..4 show outs=0x1A48D7, 0x1, 0xFFFFF, 0x1FFFFF with index 0..3; outs_last only at cycle 4; ctrl_ready=1 again at cycle 5.
- Backpressure: outs_ready=0 for cycles 2..5 of a burst -> outs=0x1 and index 1 held stable for 4 cycles; burst completes with all 4 beats in order, none duplicated or dropped.
- Token during RUN: ctrl_valid held high continuously -> ctrl_ready=0 throughout RUN; second burst begins exactly one IDLE cycle after the last beat; 2 tokens produce 8 beats in 10 cycles.
- Reset mid-burst: rst at the edge after beat index 1 fires -> next cycle outs_valid=0, outs=0, ctrl_ready=1; a new token restarts at index 0 with 0x1A48D7.
- NUM_COEFS=1, COEF_TABLE=32'h001A48D7: each token -> one beat, outs=0x1A48D7, outs_last=1; random outs_ready over 100 tokens -> 100 beats, all equal to 0x1A48D7.

Source files
------------

// File: rtl/handshake_coef_sequencer.sv
// handshake_coef_sequencer: emits NUM_COEFS table constants per accepted ctrl token on a valid/ready channel.
module handshake_coef_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_COEFS = 4,
  parameter logic [NUM_COEFS*DATA_WIDTH-1:0] COEF_TABLE = {32'h001FFFFF, 32'h000FFFFF, 32'h00000001, 32'h001A48D7},
  localparam int IDX_W = (NUM_COEFS > 1) ? $clog2(NUM_COEFS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [IDX_W-1:0]      outs_index,
  output logic                  outs_last,
  output logic                  outs_valid,
  input  logic                  outs_ready
);
  typedef enum logic {IDLE, RUN} state_e;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFS - 1);
  state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] outs_q, outs_d;
  logic [IDX_W-1:0] idx_q, idx_d, nxt;
  logic run, fire, last;
  always_comb begin
    run = state_q == RUN;
    last = idx_q == LAST_IDX;
    fire = run && outs_ready;
    nxt = idx_q + IDX_W'(1);
    state_d = run ? ((fire && last) ? IDLE : RUN) : (ctrl_valid ? RUN : IDLE);
    idx_d = (fire && !last) ? nxt : ((fire || !run) ? '0 : idx_q);
    outs_d = (!run && ctrl_valid) ? COEF_TABLE[DATA_WIDTH-1:0]
           : (fire && !last) ? COEF_TABLE[int'(nxt)*DATA_WIDTH +: DATA_WIDTH]
           : outs_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      outs_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      outs_q <= outs_d;
      idx_q <= idx_d;
    end
  end
  assign ctrl_ready = state_q == IDLE;
  assign outs_valid = state_q == RUN;
  assign outs = outs_q;
  assign outs_index = idx_q;
  assign outs_last = outs_valid && (idx_q == LAST_IDX);
endmodule

// File: tb/tb_handshake_coef_sequencer.sv
// tb_handshake_coef_sequencer: queue-based reference model against default and single-entry sequencers.
module tb_handshake_coef_sequencer;
  localparam int N = 4;
  localparam logic [127:0] TBL = {32'h001FFFFF, 32'h000FFFFF, 32'h00000001, 32'h001A48D7};
  logic clk = 0;
  logic rst, ctrl_valid, outs_ready;
  logic ctrl_ready, outs_last, outs_valid;
  logic [31:0] outs;
  logic [1:0] outs_index;
  logic c1_ready, last1, valid1;
  logic [31:0] outs1;
  logic [0:0] idx1;
  int q[$], q1[$];
  int errors = 0, checks = 0, fires = 0, beats1 = 0, tok1 = 0;
  logic [31:0] exp_seq [4] = '{32'h001A48D7, 32'h00000001, 32'h000FFFFF, 32'h001FFFFF};

  always #5 clk = ~clk;

  handshake_coef_sequencer dut (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .outs(outs), .outs_index(outs_index), .outs_last(outs_last),
    .outs_valid(outs_valid), .outs_ready(outs_ready)
  );

  handshake_coef_sequencer #(.NUM_COEFS(1), .COEF_TABLE(32'h001A48D7)) dut1 (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(c1_ready),
    .outs(outs1), .outs_index(idx1), .outs_last(last1),
    .outs_valid(valid1), .outs_ready(outs_ready)
  );

  function automatic logic [31:0] coef(int i);
    return TBL[i*32 +: 32];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("valid", outs_valid, q.size() > 0);
    chk("ready", ctrl_ready, q.size() == 0);
    if (q.size() > 0) begin
      chk("outs", outs, coef(q[0]));
      chk("index", outs_index, q[0]);
      chk("last", outs_last, q[0] == N - 1);
    end else chk("last_idle", outs_last, 0);
    chk("valid1", valid1, q1.size() > 0);
    chk("ready1", c1_ready, q1.size() == 0);
    chk("last1", last1, q1.size() > 0);
    chk("index1", idx1, 0);
    if (q1.size() > 0) chk("outs1", outs1, 32'h001A48D7);
  endtask

  task automatic cycle(input logic r, input logic cv, input logic ordy);
    rst = r;
    ctrl_valid = cv;
    outs_ready = ordy;
    if (!r && outs_valid && ordy) fires++;
    if (!r && valid1 && ordy) beats1++;
    @(posedge clk);
    if (r) begin
      q.delete();
      q1.delete();
    end else begin
      if (q.size() > 0) begin
        if (ordy) void'(q.pop_front());
      end else if (cv) for (int i = 0; i < N; i++) q.push_back(i);
      if (q1.size() > 0) begin
        if (ordy) void'(q1.pop_front());
      end else if (cv) begin
        q1.push_back(0);
        tok1++;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int f0;
    rst = 1;
    ctrl_valid = 0;
    outs_ready = 1;
    @(negedge clk);
    cycle(1, 0, 1);
    cycle(1, 0, 1);
    chk("rst_outs", outs, 0);
    chk("rst_outs1", outs1, 0);
    repeat (3) begin
      cycle(0, 0, 1);
      chk("idle_outs", outs, 0);
    end
    cycle(0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      chk("burst_seq", outs, exp_seq[k]);
      chk("burst_last", outs_last, k == 3);
      cycle(0, 0, 1);
    end
    chk("burst_ready_again", ctrl_ready, 1);
    cycle(0, 1, 1);
    cycle(0, 0, 1);
    repeat (4) begin
      chk("bp_hold", outs, 32'h00000001);
      chk("bp_idx", outs_index, 1);
      cycle(0, 0, 0);
    end
    repeat (4) cycle(0, 0, 1);
    f0 = fires;
    repeat (10) cycle(0, 1, 1);
    chk("throughput", fires - f0, 8);
    cycle(0, 1, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    cycle(1, 0, 1);
    chk("mid_rst_outs", outs, 0);
    chk("mid_rst_valid", outs_valid, 0);
    chk("mid_rst_ready", ctrl_ready, 1);
    cycle(0, 1, 1);
    chk("restart_outs", outs, 32'h001A48D7);
    chk("restart_idx", outs_index, 0);
    repeat (6) cycle(0, 0, 1);
    beats1 = 0;
    tok1 = 0;
    for (int c = 0; c < 3000 && tok1 < 100; c++)
      cycle(0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    repeat (6) cycle(0, 0, 1);
    chk("tok_budget", tok1 >= 100, 1);
    chk("beats1", beats1, tok1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
